// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: divides the system clock into quarter/half-frame strobes
// and maintains the frame IRQ flag. Supports 4-step and 5-step sequences.
module apu_frame_sequencer #(
    parameter int unsigned CLK_DIV = 7457,
    parameter int unsigned DIV_W   = 16
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iWrite,
    input  logic       iMode,
    input  logic       iIrqDisable,
    input  logic       iIrqAck,
    output logic       oQuarter,
    output logic       oHalf,
    output logic       oIrq,
    output logic [2:0] oStep
);

    localparam logic [DIV_W-1:0] DivLast = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       step_q, step_d;
    logic             mode_q, mode_d;
    logic             irq_dis_q, irq_dis_d;
    logic             irq_flag_q, irq_flag_d;
    logic             quarter_q, quarter_d;
    logic             half_q, half_d;

    logic             tc;
    logic [2:0]       step_last;

    assign tc        = (div_q == DivLast);
    assign step_last = mode_q ? 3'd4 : 3'd3;

    // Next-state: write beats terminal count; an IRQ set beats an acknowledge.
    always_comb begin
        div_d      = tc ? '0 : div_q + 1'b1;
        step_d     = step_q;
        mode_d     = mode_q;
        irq_dis_d  = irq_dis_q;
        irq_flag_d = irq_flag_q;
        quarter_d  = 1'b0;
        half_d     = 1'b0;

        if (iIrqAck) begin
            irq_flag_d = 1'b0;
        end

        if (iWrite) begin
            mode_d    = iMode;
            irq_dis_d = iIrqDisable;
            div_d     = '0;
            step_d    = '0;
            if (iIrqDisable) begin
                irq_flag_d = 1'b0;
            end
            // 5-step mode clocks the units immediately on the write
            quarter_d = iMode;
            half_d    = iMode;
        end else if (tc) begin
            // Out-of-range step recovers to 0 rather than running away
            step_d = (step_q >= step_last) ? 3'd0 : step_q + 3'd1;
            if (!mode_q) begin
                quarter_d = 1'b1;
                half_d    = (step_q == 3'd1) || (step_q == 3'd3);
                if ((step_q == 3'd3) && !irq_dis_q) begin
                    irq_flag_d = 1'b1;
                end
            end else begin
                quarter_d = (step_q != 3'd3);
                half_d    = (step_q == 3'd1) || (step_q == 3'd4);
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            div_q      <= '0;
            step_q     <= '0;
            mode_q     <= 1'b0;
            irq_dis_q  <= 1'b0;
            irq_flag_q <= 1'b0;
            quarter_q  <= 1'b0;
            half_q     <= 1'b0;
        end else begin
            div_q      <= div_d;
            step_q     <= step_d;
            mode_q     <= mode_d;
            irq_dis_q  <= irq_dis_d;
            irq_flag_q <= irq_flag_d;
            quarter_q  <= quarter_d;
            half_q     <= half_d;
        end
    end

    assign oQuarter = quarter_q;
    assign oHalf    = half_q;
    assign oIrq     = irq_flag_q;
    assign oStep    = step_q;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Self-checking bench for apu_frame_sequencer: directed test-plan scenarios plus
// randomized traffic, all checked against a cycle-count based reference model.
module tb_apu_frame_sequencer;

    localparam int unsigned CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst, wr, mode, irq_dis, ack;
    logic       q, h, irq;
    logic [2:0] step;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    apu_frame_sequencer #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (16)
    ) dut (
        .iClk        (clk),
        .iReset      (rst),
        .iWrite      (wr),
        .iMode       (mode),
        .iIrqDisable (irq_dis),
        .iIrqAck     (ack),
        .oQuarter    (q),
        .oHalf       (h),
        .oIrq        (irq),
        .oStep       (step)
    );

    // Reference model: cycles elapsed since the divider restarted, plus mode/IRQ state.
    int unsigned cnt;
    bit m_mode, m_dis, m_irq, e_q, e_h;
    bit q_tab4[4] = '{1, 1, 1, 1};
    bit h_tab4[4] = '{0, 1, 0, 1};
    bit q_tab5[5] = '{1, 1, 1, 0, 1};
    bit h_tab5[5] = '{0, 1, 0, 0, 1};
    int tcyc;  // cycle number since last reset release

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, tcyc);
    endtask

    function automatic int unsigned nsteps(input bit md);
        return md ? 5 : 4;
    endfunction

    function automatic logic [2:0] m_step();
        return 3'((cnt / CLK_DIV) % nsteps(m_mode));
    endfunction

    task automatic model_edge();
        int unsigned s;
        bit tc;
        if (rst) begin
            cnt = 0; m_mode = 0; m_dis = 0; m_irq = 0; e_q = 0; e_h = 0;
            return;
        end
        if (wr) begin
            m_mode = mode;
            m_dis  = irq_dis;
            cnt    = 0;
            if (irq_dis || ack) m_irq = 0;
            e_q = mode;
            e_h = mode;
            return;
        end
        tc = ((cnt % CLK_DIV) == CLK_DIV - 1);
        s  = (cnt / CLK_DIV) % nsteps(m_mode);
        e_q = 0;
        e_h = 0;
        if (ack) m_irq = 0;
        if (tc) begin
            e_q = m_mode ? q_tab5[s] : q_tab4[s];
            e_h = m_mode ? h_tab5[s] : h_tab4[s];
            if (!m_mode && s == 3 && !m_dis) m_irq = 1;
        end
        cnt++;
    endtask

    // One clock: inputs already driven; model follows the edge; compare; drop strobes.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        tcyc = rst ? 0 : tcyc + 1;
        #1;
        check("quarter", q, e_q);
        check("half", h, e_h);
        check("irq", irq, m_irq);
        check("step", step, m_step());
        rst = 0; wr = 0; ack = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        cyc();
    endtask

    task automatic do_write(input bit md, input bit dis);
        wr = 1; mode = md; irq_dis = dis;
        cyc();
    endtask

    initial begin
        rst = 1; wr = 0; mode = 0; irq_dis = 0; ack = 0; tcyc = 0;
        cnt = 0; m_mode = 0; m_dis = 0; m_irq = 0; e_q = 0; e_h = 0;

        // Reset state
        do_reset();
        check("rst_q", q, 0); check("rst_h", h, 0); check("rst_irq", irq, 0);
        check("rst_step", step, 0);

        // 4-step periodicity
        for (int k = 1; k <= 20; k++) begin
            cyc();
            check("p4_q", q, (k % 4) == 0);
            check("p4_h", h, (k % 8) == 0);
            check("p4_irq", irq, k >= 16);
        end
        // Acknowledge clears the flag one cycle later (cycle 20 is a step-0 strobe)
        ack = 1;
        cyc();
        check("ack_clr", irq, 0);

        // 5-step mode with write in cycle 2
        do_reset();
        cyc(); cyc();
        do_write(1, 0);
        check("w5_q", q, 1); check("w5_h", h, 1);
        for (int k = 4; k <= 24; k++) begin
            cyc();
            check("p5_q", q, (k == 7) || (k == 11) || (k == 15) || (k == 23));
            check("p5_h", h, (k == 11) || (k == 23));
            check("p5_irq", irq, 0);
        end

        // Write/TC collision at step-1 TC (cycle 7)
        do_reset();
        repeat (7) cyc();
        do_write(0, 0);
        check("col_h", h, 0); check("col_q", q, 0); check("col_step", step, 0);
        for (int k = 9; k <= 12; k++) begin
            cyc();
            check("col_next_q", q, k == 12);
        end

        // Ack coincident with step-3 TC (cycle 15): set wins
        do_reset();
        repeat (15) cyc();
        ack = 1;
        cyc();
        check("ack_vs_set", irq, 1);

        // IRQ disabled: flag never rises
        do_write(0, 1);
        check("dis_clr", irq, 0);
        repeat (32) begin
            cyc();
            check("dis_irq", irq, 0);
        end

        // Reset mid-sequence in 5-step mode at step 2 with flag set
        do_reset();
        repeat (17) cyc();
        do_write(1, 0);
        check("mid_irq_kept", irq, 1);
        for (int g = 0; g < 40 && step != 3'd2; g++) cyc();
        check("mid_at_step2", step, 2);
        do_reset();
        check("mid_q", q, 0); check("mid_h", h, 0); check("mid_irq", irq, 0);
        check("mid_step", step, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("mid_first_q", q, k == 4);
        end

        // Length counter hookup: second half strobe after reset lands in cycle 16
        do_reset();
        begin
            int halves = 0;
            int second = -1;
            for (int k = 1; k <= 20; k++) begin
                cyc();
                if (h) begin
                    halves++;
                    if (halves == 2) second = k;
                end
            end
            check("len_second_half", second, 16);
        end

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst     = ($urandom_range(0, 299) == 0);
            wr      = ($urandom_range(0, 39) == 0);
            mode    = 1'($urandom);
            irq_dis = ($urandom_range(0, 3) == 0);
            ack     = ($urandom_range(0, 9) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
